// File: rtl/f3_alap_acc.sv
// f3_alap_acc: multi-beat accumulate stage after F2 with sticky signed overflow and beat count
module f3_alap_acc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             last,
  input  logic [WIDTH-1:0] f2_in,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic ovf_q, ovf_nx;
  logic accept, take, first;
  logic [WIDTH+1:0] base_w, f2_w, in1_w, sum_w;
  logic fits;
  assign in_ready  = (state != DONE) || out_ready;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign first     = (state != ACC);
  assign out       = acc;
  assign count     = cnt;
  assign ovf       = ovf_q;
  // exact signed sum in WIDTH+2 bits, next-state and next register values
  always_comb begin
    base_w   = first ? '0 : {{2{acc[WIDTH-1]}}, acc};
    f2_w     = {{2{f2_in[WIDTH-1]}}, f2_in};
    in1_w    = {{2{in1[WIDTH-1]}}, in1};
    sum_w    = op == OP_LOAD ? f2_w :
               op == OP_ADD  ? base_w + f2_w :
               op == OP_SUB  ? base_w - f2_w : base_w + f2_w + in1_w;
    fits     = (sum_w[WIDTH+1:WIDTH-1] == 3'b000) || (sum_w[WIDTH+1:WIDTH-1] == 3'b111);
    acc_nx   = accept ? sum_w[WIDTH-1:0] : acc;
    cnt_nx   = !accept ? cnt : first ? CNT_W'(1) : cnt == CNT_MAX ? cnt : cnt + CNT_W'(1);
    ovf_nx   = !accept ? ovf_q : ((first ? 1'b0 : ovf_q) || (op != OP_LOAD && !fits));
    state_nx = accept ? (last ? DONE : ACC) : take ? IDLE : state;
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf_q <= ovf_nx;
    end
  end
endmodule

// File: tb/tb_f3_alap_acc.sv
// tb_f3_alap_acc: scoreboard bench with directed and randomized sequences against an arithmetic model
module tb_f3_alap_acc;
  logic        clk, rst_n, in_valid, in_ready, last, out_valid, out_ready, ovf;
  logic [1:0]  op;
  logic [31:0] f2_in, in1, out;
  logic [7:0]  count;
  int tests = 0, fails = 0;
  bit rnd = 0;
  typedef struct {logic [31:0] o; logic [7:0] c; logic v;} res_t;
  res_t q[$];
  bit          m_open = 0;
  logic [31:0] m_acc;
  int          m_cnt;
  bit          m_ovf;

  f3_alap_acc #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .last(last),
    .f2_in(f2_in), .in1(in1), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .count(count), .ovf(ovf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic l, input logic [31:0] f, input logic [31:0] i);
    longint a, b, c, r;
    if (!m_open) begin m_acc = 0; m_cnt = 0; m_ovf = 0; end
    a = longint'($signed(m_acc));
    b = longint'($signed(f));
    c = longint'($signed(i));
    case (o)
      2'd0: r = b;
      2'd1: r = a + b;
      2'd2: r = a - b;
      default: r = a + b + c;
    endcase
    if (o != 2'd0 && (r > 64'sd2147483647 || r < -64'sd2147483648)) m_ovf = 1;
    m_acc = r[31:0];
    m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
    if (l) q.push_back('{m_acc, 8'(m_cnt), m_ovf});
    m_open = !l;
  endtask

  task automatic beat(input logic [1:0] o, input logic l, input logic [31:0] f, input logic [31:0] i);
    bit ok = 0;
    in_valid = 1; op = o; last = l; f2_in = f; in1 = i;
    for (int t = 0; t < 200; t++) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) model(o, l, f, i);
    else begin tests++; fails++; $display("FAIL beat_timeout: in_ready stuck 0, required 1"); end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic expect_res(input logic [31:0] eo, input logic [7:0] ec, input logic ev);
    bit seen = 0;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (out_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check("res_valid", 64'(seen), 64'd1);
    check("res_out", 64'(out), 64'(eo));
    check("res_count", 64'(count), 64'(ec));
    check("res_ovf", 64'(ovf), 64'(ev));
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'h7FFFFFF0 + 32'($urandom_range(0, 15));
      1: return 32'h80000000 + 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // monitor: a take happens at the next rising edge whenever out_valid && out_ready mid-cycle
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: out=0x%0h with empty scoreboard, required no result", out);
      end else begin
        res_t e;
        e = q.pop_front();
        check("sb_out", 64'(out), 64'(e.o));
        check("sb_count", 64'(count), 64'(e.c));
        check("sb_ovf", 64'(ovf), 64'(e.v));
      end
    end
  end

  initial begin
    rst_n = 0; in_valid = 0; op = 0; last = 0; f2_in = 0; in1 = 0; out_ready = 0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    beat(2'd0, 1'b0, 32'h5, 32'h0);
    #3;
    rst_n = 0;
    #1;
    q.delete();
    m_open = 0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    beat(2'd0, 1'b1, 32'h10, 32'h0);
    expect_res(32'h10, 8'd1, 1'b0);
    beat(2'd0, 1'b1, 32'h10, 32'h0);
    expect_res(32'h10, 8'd1, 1'b0);
    beat(2'd0, 1'b0, 32'h18, 32'h0);
    beat(2'd1, 1'b0, 32'h08, 32'h0);
    beat(2'd2, 1'b1, 32'h04, 32'h0);
    expect_res(32'h1C, 8'd3, 1'b0);
    beat(2'd3, 1'b1, 32'h18, 32'h2);
    expect_res(32'h1A, 8'd1, 1'b0);
    beat(2'd0, 1'b0, 32'h7FFFFFF8, 32'h0);
    beat(2'd1, 1'b1, 32'h10, 32'h0);
    expect_res(32'h80000008, 8'd2, 1'b1);
    beat(2'd0, 1'b1, 32'h1, 32'h0);
    expect_res(32'h1, 8'd1, 1'b0);
    beat(2'd0, 1'b1, 32'h7, 32'h0);
    in_valid = 1; op = 2'd0; last = 1; f2_in = 32'h5; in1 = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_stable", 64'(out), 64'h7);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1;
    beat(2'd0, 1'b1, 32'h5, 32'h0);
    out_ready = 0;
    #1;
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_out", 64'(out), 64'h5);
    @(negedge clk);
    expect_res(32'h5, 8'd1, 1'b0);
    for (int k = 0; k < 300; k++) beat(2'd1, k == 299, 32'h1, 32'h0);
    expect_res(32'd300, 8'd255, 1'b0);
    rnd = 1;
    for (int s = 0; s < 200; s++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        beat(2'($urandom_range(0, 3)), k == len - 1, pick(), pick());
        if ($urandom_range(0, 3) == 0) begin
          out_ready = ($urandom_range(0, 1) != 0);
          @(negedge clk);
        end
      end
    end
    rnd = 0;
    out_ready = 1;
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);
    out_ready = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
